// File: rtl/pio_chk_pkg.sv
// rtl/pio_chk_pkg.sv - shared state enum, PRNG step and pin-mode encodings for the PIO lockstep checker
package pio_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARM0,
    S_WARM1,
    S_WARMZ,
    S_APPLY,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } chk_state_e;

  localparam logic [63:0] DEFAULT_SEED = 64'd88172645463325252;

  // Pin-mode select values produced from the PRNG (3 and 4 mean "flip a stim bit").
  localparam logic [2:0] PIN_SEL_Z    = 3'd0;
  localparam logic [2:0] PIN_SEL_DRV0 = 3'd1;
  localparam logic [2:0] PIN_SEL_DRV1 = 3'd2;

  // Position of clk_in inside the control stimulus vector.
  localparam int CLK_IN_BIT = 1;

  function automatic logic [63:0] xorshift64(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

endpackage

// File: rtl/xorshift64_prng.sv
// rtl/xorshift64_prng.sv - xorshift64 state register with reseed and step controls
module xorshift64_prng
  import pio_chk_pkg::*;
#(
  parameter logic [63:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        reseed,
  input  logic        step,
  output logic [63:0] state
);

  // Reseed takes priority over step so every run starts from the same point.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SEED;
    end else if (reseed) begin
      state <= SEED;
    end else if (step) begin
      state <= xorshift64(state);
    end
  end

endmodule

// File: rtl/pio_lockstep_checker.sv
// rtl/pio_lockstep_checker.sv - gold/gate PIO lockstep stimulus and compare engine (option: FIRST_ERR_CAPTURE_EN)
module pio_lockstep_checker
  import pio_chk_pkg::*;
#(
  parameter int          STIM_W      = 6,
  parameter int          RESP_W      = 4,
  parameter int          NUM_VECTORS = 1000,
  parameter int          WARMUP      = 5,
  parameter int          SETTLE      = 1,
  parameter int          ERR_W       = 16,
  parameter logic [63:0] SEED        = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [RESP_W-1:0] cmp_mask,
  input  logic [RESP_W-1:0] gold_resp,
  input  logic [RESP_W-1:0] gate_resp,
  output logic [STIM_W-1:0] stim,
  output logic              pin_oe,
  output logic              pin_val,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [31:0]       first_err_idx,
  output logic [RESP_W-1:0] first_err_diff
);

  localparam logic [31:0]      LAST_VEC    = 32'(NUM_VECTORS) - 32'd1;
  localparam logic [31:0]      WARM_LAST   = 32'(WARMUP) - 32'd1;
  localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE) - 32'd1;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  chk_state_e        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       vec_idx_q, vec_idx_d;
  logic [STIM_W-1:0] stim_q, stim_d;
  logic              pin_oe_q, pin_oe_d;
  logic              pin_val_q, pin_val_d;
  logic [RESP_W-1:0] mask_q, mask_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic [63:0]       prng_state;
  logic [63:0]       prng_next;
  logic              prng_reseed;
  logic              prng_step;
  logic [2:0]        sel;
  logic [15:0]       flip_bit;
  logic [RESP_W-1:0] diff;
  logic              accept;

`ifdef FIRST_ERR_CAPTURE_EN
  logic [31:0]       first_idx_q, first_idx_d;
  logic [RESP_W-1:0] first_diff_q, first_diff_d;
  logic              captured_q, captured_d;
`endif

  xorshift64_prng #(
    .SEED(SEED)
  ) u_prng (
    .clk   (clk),
    .resetn(resetn),
    .reseed(prng_reseed),
    .step  (prng_step),
    .state (prng_state)
  );

  // The stimulus decision uses the value the PRNG is about to hold after this APPLY step.
  assign prng_next = xorshift64(prng_state);
  assign sel       = 3'(prng_next[15:0] % 16'd5);
  assign flip_bit  = prng_next[31:16] % 16'(STIM_W);
  assign diff      = (gold_resp ^ gate_resp) & mask_q;
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state, stimulus and scoreboard update; everything holds unless a state acts on it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_idx_d   = vec_idx_q;
    stim_d      = stim_q;
    pin_oe_d    = pin_oe_q;
    pin_val_d   = pin_val_q;
    mask_d      = mask_q;
    err_d       = err_q;
    prng_reseed = 1'b0;
    prng_step   = 1'b0;
`ifdef FIRST_ERR_CAPTURE_EN
    first_idx_d  = first_idx_q;
    first_diff_d = first_diff_q;
    captured_d   = captured_q;
`endif
    if (accept) begin
      state_d     = S_WARM0;
      cnt_d       = '0;
      vec_idx_d   = '0;
      stim_d      = '0;
      pin_oe_d    = 1'b1;
      pin_val_d   = 1'b0;
      mask_d      = cmp_mask;
      err_d       = '0;
      prng_reseed = 1'b1;
`ifdef FIRST_ERR_CAPTURE_EN
      first_idx_d  = '1;
      first_diff_d = '0;
      captured_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_WARM0, S_WARM1, S_WARMZ: begin
          stim_d[CLK_IN_BIT] = ~stim_q[CLK_IN_BIT];
          if (cnt_q == WARM_LAST) begin
            cnt_d = '0;
            case (state_q)
              S_WARM0: begin
                state_d   = S_WARM1;
                pin_val_d = 1'b1;
              end
              S_WARM1: begin
                state_d  = S_WARMZ;
                pin_oe_d = 1'b0;
              end
              default: state_d = (NUM_VECTORS == 0) ? S_DONE : S_APPLY;
            endcase
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_APPLY: begin
          prng_step = 1'b1;
          cnt_d     = '0;
          state_d   = S_SETTLE;
          case (sel)
            PIN_SEL_Z: pin_oe_d = 1'b0;
            PIN_SEL_DRV0: begin
              pin_oe_d  = 1'b1;
              pin_val_d = 1'b0;
            end
            PIN_SEL_DRV1: begin
              pin_oe_d  = 1'b1;
              pin_val_d = 1'b1;
            end
            default: stim_d = stim_q ^ (STIM_W'(1) << flip_bit);
          endcase
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = S_COMPARE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_COMPARE: begin
          if ((diff != '0) && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
          end
`ifdef FIRST_ERR_CAPTURE_EN
          if ((diff != '0) && !captured_q) begin
            first_idx_d  = vec_idx_q;
            first_diff_d = diff;
            captured_d   = 1'b1;
          end
`endif
          vec_idx_d = vec_idx_q + 32'd1;
          state_d   = (vec_idx_q == LAST_VEC) ? S_DONE : S_APPLY;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers; reset discards any partial run.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      vec_idx_q <= '0;
      stim_q    <= '0;
      pin_oe_q  <= 1'b0;
      pin_val_q <= 1'b0;
      mask_q    <= '0;
      err_q     <= '0;
`ifdef FIRST_ERR_CAPTURE_EN
      first_idx_q  <= '1;
      first_diff_q <= '0;
      captured_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_idx_q <= vec_idx_d;
      stim_q    <= stim_d;
      pin_oe_q  <= pin_oe_d;
      pin_val_q <= pin_val_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
`ifdef FIRST_ERR_CAPTURE_EN
      first_idx_q  <= first_idx_d;
      first_diff_q <= first_diff_d;
      captured_q   <= captured_d;
`endif
    end
  end

  assign stim      = stim_q;
  assign pin_oe    = pin_oe_q;
  assign pin_val   = pin_val_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;

`ifdef FIRST_ERR_CAPTURE_EN
  assign first_err_idx  = first_idx_q;
  assign first_err_diff = first_diff_q;
`else
  assign first_err_idx  = '1;
  assign first_err_diff = '0;
`endif

endmodule

// File: tb/tb_pio_lockstep_checker.sv
// tb/tb_pio_lockstep_checker.sv - self-checking bench for pio_lockstep_checker
module tb_pio_lockstep_checker;

`ifdef FIRST_ERR_CAPTURE_EN
  localparam bit CAPTURE = 1'b1;
`else
  localparam bit CAPTURE = 1'b0;
`endif
  localparam logic [63:0] TB_SEED = 64'd88172645463325252;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance: 16 vectors, default timing.
  logic        start_m = 1'b0;
  logic [3:0]  mask_m = 4'hF;
  logic [3:0]  flip_m = 4'h0;
  int          flip_from = 0;
  int          cyc = 0;
  logic [3:0]  gold_m, gate_m;
  logic [5:0]  stim_m;
  logic        oe_m, val_m, busy_m, done_m, pass_m;
  logic [15:0] err_m;
  logic [31:0] fidx_m;
  logic [3:0]  fdiff_m;

  assign gold_m = {stim_m[5] ^ stim_m[0], oe_m, stim_m[2], stim_m[3] ^ val_m};
  assign gate_m = (cyc >= 16 + 3 * flip_from) ? (gold_m ^ flip_m) : gold_m;

  pio_lockstep_checker #(.NUM_VECTORS(16)) u_main (
    .clk(clk), .resetn(resetn), .start(start_m), .cmp_mask(mask_m),
    .gold_resp(gold_m), .gate_resp(gate_m), .stim(stim_m), .pin_oe(oe_m),
    .pin_val(val_m), .busy(busy_m), .done(done_m), .pass(pass_m),
    .err_count(err_m), .first_err_idx(fidx_m), .first_err_diff(fdiff_m)
  );

  // Saturation instance: 4-bit counter, 20 always-mismatching vectors.
  logic        start_s = 1'b0;
  logic [3:0]  gold_s, gate_s;
  logic [5:0]  stim_s;
  logic        oe_s, val_s, busy_s, done_s, pass_s;
  logic [3:0]  err_s;
  logic [31:0] fidx_s;
  logic [3:0]  fdiff_s;

  assign gold_s = {stim_s[1], oe_s, stim_s[4], val_s};
  assign gate_s = gold_s ^ 4'b0001;

  pio_lockstep_checker #(.NUM_VECTORS(20), .ERR_W(4)) u_sat (
    .clk(clk), .resetn(resetn), .start(start_s), .cmp_mask(4'hF),
    .gold_resp(gold_s), .gate_resp(gate_s), .stim(stim_s), .pin_oe(oe_s),
    .pin_val(val_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .first_err_idx(fidx_s), .first_err_diff(fdiff_s)
  );

  // Empty instance: zero vectors.
  logic        start_e = 1'b0;
  logic [3:0]  gold_e;
  logic [5:0]  stim_e;
  logic        oe_e, val_e, busy_e, done_e, pass_e;
  logic [15:0] err_e;
  logic [31:0] fidx_e;
  logic [3:0]  fdiff_e;

  assign gold_e = {stim_e[3:1], oe_e};

  pio_lockstep_checker #(.NUM_VECTORS(0)) u_empty (
    .clk(clk), .resetn(resetn), .start(start_e), .cmp_mask(4'hF),
    .gold_resp(gold_e), .gate_resp(gold_e), .stim(stim_e), .pin_oe(oe_e),
    .pin_val(val_e), .busy(busy_e), .done(done_e), .pass(pass_e),
    .err_count(err_e), .first_err_idx(fidx_e), .first_err_diff(fdiff_e)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  flip;
    int          from;
    int          exp_err;
    logic        exp_pass;
    logic [31:0] exp_idx;
    logic [3:0]  exp_diff;
  } vec_t;

  vec_t       tbl [7];
  logic [7:0] trace0 [0:63];

  function automatic logic [63:0] bench_xs(input logic [63:0] v);
    logic [63:0] t;
    t = v;
    t = t ^ {t[50:0], 13'b0};
    t = t ^ {7'b0, t[63:7]};
    t = t ^ {t[46:0], 17'b0};
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One 16-vector run on the main instance, checked cycle by cycle against a reference model.
  task automatic run_row(input int r, input int row, input bit poke);
    logic [63:0] p;
    logic [5:0]  ms;
    logic        moe, mval;
    logic [15:0] s16;
    logic [7:0]  snap;
    int          lat, trace_bad, model_bad, vi;
    p = TB_SEED; ms = '0; moe = 1'b0; mval = 1'b0;
    lat = -1; trace_bad = 0; model_bad = 0;
    mask_m = tbl[row].mask; flip_m = tbl[row].flip; flip_from = tbl[row].from;
    @(negedge clk);
    start_m = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 200 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      start_m = poke && (c == 30);
      cyc = c;
      if (c == 1) begin
        ms = '0; moe = 1'b1; mval = 1'b0;
      end else if (c <= 16) begin
        ms[1] = ~ms[1];
        if (c == 6) mval = 1'b1;
        if (c == 11) moe = 1'b0;
      end else if (((c - 17) % 3) == 0 && ((c - 17) / 3) < 16) begin
        p = bench_xs(p);
        s16 = p[15:0] % 16'd5;
        vi = int'(p[31:16] % 16'd6);
        case (s16)
          16'd0: moe = 1'b0;
          16'd1: begin moe = 1'b1; mval = 1'b0; end
          16'd2: begin moe = 1'b1; mval = 1'b1; end
          default: ms[vi] = ~ms[vi];
        endcase
      end
      if (stim_m !== ms || oe_m !== moe || (moe && val_m !== mval)) model_bad++;
      snap = {stim_m, oe_m, val_m};
      if (c <= 64) begin
        if (r == 0) trace0[c-1] = snap;
        else if (snap !== trace0[c-1]) trace_bad++;
      end
      if (done_m) lat = c;
    end
    cyc = 0;
    chk($sformatf("r%0d_latency", r), 64'(lat), 64);
    chk($sformatf("r%0d_busy", r), 64'(busy_m), 0);
    chk($sformatf("r%0d_err", r), 64'(err_m), 64'(tbl[row].exp_err));
    chk($sformatf("r%0d_pass", r), 64'(pass_m), 64'(tbl[row].exp_pass));
    chk($sformatf("r%0d_first_idx", r), 64'(fidx_m), CAPTURE ? 64'(tbl[row].exp_idx) : 64'hFFFF_FFFF);
    chk($sformatf("r%0d_first_diff", r), 64'(fdiff_m), CAPTURE ? 64'(tbl[row].exp_diff) : 64'h0);
    chk($sformatf("r%0d_model", r), 64'(model_bad), 0);
    if (r != 0) chk($sformatf("r%0d_trace", r), 64'(trace_bad), 0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_stim"}, 64'(stim_m), 0);
    chk({tag, "_pin"}, 64'({oe_m, val_m}), 0);
    chk({tag, "_flags"}, 64'({busy_m, done_m, pass_m}), 0);
    chk({tag, "_err"}, 64'(err_m), 0);
    chk({tag, "_first_idx"}, 64'(fidx_m), 64'hFFFF_FFFF);
    chk({tag, "_first_diff"}, 64'(fdiff_m), 0);
  endtask

  initial begin
    int lat_s, lat_e;
    tbl[0] = '{4'hF, 4'h0, 0,  0,  1'b1, 32'hFFFF_FFFF, 4'h0};
    tbl[1] = '{4'hF, 4'h1, 0,  16, 1'b0, 32'd0,         4'h1};
    tbl[2] = '{4'hE, 4'h1, 0,  0,  1'b1, 32'hFFFF_FFFF, 4'h0};
    tbl[3] = '{4'h1, 4'h6, 0,  0,  1'b1, 32'hFFFF_FFFF, 4'h0};
    tbl[4] = '{4'hF, 4'h6, 5,  11, 1'b0, 32'd5,         4'h6};
    tbl[5] = '{4'h4, 4'h6, 10, 6,  1'b0, 32'd10,        4'h4};
    tbl[6] = '{4'h8, 4'h9, 15, 1,  1'b0, 32'd15,        4'h8};

    repeat (3) @(posedge clk);
    #1;
    chk_cleared("in_reset");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk_cleared("after_reset");

    for (int i = 0; i < 7; i++) run_row(i, i, i == 2);

    // Reset in the middle of a mismatching run must clear everything before the next edge.
    mask_m = 4'hF; flip_m = 4'h1; flip_from = 0;
    @(negedge clk);
    start_m = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      start_m = 1'b0;
      cyc = c;
    end
    chk("mid_busy", 64'(busy_m), 1);
    chk("mid_err_nonzero", 64'(err_m != 0), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk_cleared("async_reset");
    cyc = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    run_row(7, 1, 1'b0);

    // Saturating counter and empty run side by side.
    lat_s = -1; lat_e = -1;
    @(negedge clk);
    start_s = 1'b1;
    start_e = 1'b1;
    for (int c = 1; c <= 200 && (lat_s < 0 || lat_e < 0); c++) begin
      @(posedge clk);
      #1;
      start_s = 1'b0;
      start_e = 1'b0;
      if (done_e && lat_e < 0) lat_e = c;
      if (done_s && lat_s < 0) lat_s = c;
    end
    chk("empty_latency", 64'(lat_e), 16);
    chk("empty_pass", 64'(pass_e), 1);
    chk("empty_err", 64'(err_e), 0);
    chk("sat_latency", 64'(lat_s), 76);
    chk("sat_err", 64'(err_s), 15);
    chk("sat_pass", 64'(pass_s), 0);
    chk("sat_first_idx", 64'(fidx_s), CAPTURE ? 64'd0 : 64'hFFFF_FFFF);
    chk("sat_first_diff", 64'(fdiff_s), CAPTURE ? 64'd1 : 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_done_held", 64'({done_s, busy_s}), 64'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_lockstep_checker.md
Name: pio_lockstep_checker

Overview:
- Synthesizable, parametrised successor to the PIO gold/gate simulation bench.
- Generates pseudo-random PIO stimulus from a xorshift64 PRNG and drives one shared stimulus vector to two DUT instances (gold and gate).
- Compares their responses under a per-bit mask and reports pass/fail, an error count and the first mismatch.
- Sits on-chip or in a bench wrapper, so gold-vs-gate equivalence of IO cells can be run in hardware or in any simulator.

Parameters:
- STIM_W, 6, width of control stimulus (latch_in, clk_in, clk_out, oen, dout_0, dout_1 by default).
- RESP_W, 4, width of each response vector (pin, global, din_0, din_1).
- NUM_VECTORS, 1000, random vectors per run; 0 is legal.
- WARMUP, 5, cycles per warm-up phase.
- SETTLE, 1, cycles between stimulus update and compare; at least 1.
- ERR_W, 16, error counter width; the counter saturates.
- SEED, 64'd88172645463325252, PRNG seed; must be nonzero.

Ports:
- clk  in  1  single clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a run
- cmp_mask  in  RESP_W  1 = bit is compared; sampled at start
- gold_resp  in  RESP_W  gold DUT response
- gate_resp  in  RESP_W  gate DUT response
- stim  out  STIM_W  control stimulus to both DUTs
- pin_oe  out  1  checker drives the shared pin when 1
- pin_val  out  1  value driven on the pin when pin_oe=1
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  valid when done; 1 iff err_count==0
- err_count  out  ERR_W  masked-mismatch compare count
- first_err_idx  out  32  vector index of first mismatch
- first_err_diff  out  RESP_W  (gold^gate)&mask at first mismatch

Behaviour:
- Reset (async assert, sync deassert in the wrapper):
  - state=IDLE; prng=SEED; all outputs 0, except first_err_idx=all-ones.
- FSM states: IDLE -> WARM0 -> WARM1 -> WARMZ -> APPLY -> SETTLE -> COMPARE -> (APPLY | DONE).
- Start:
  - Accepted in IDLE or DONE only; start while busy is ignored.
  - On accept: busy=1, done=0, pass=0, err_count=0, first_err_* cleared, prng reseeded to SEED, stim=0.
  - Two runs are therefore bit-identical.
- Warm-up:
  - WARM0: pin_oe=1, pin_val=0 for WARMUP cycles.
  - WARM1: pin_oe=1, pin_val=1 for WARMUP cycles.
  - WARMZ: pin_oe=0 for WARMUP cycles.
  - stim[clk_in bit] toggles every cycle in all three phases; no compares occur.
- APPLY (1 cycle):
  - prng <= xorshift64(prng), using <<13, >>7, <<17 in sequence.
  - Using the new value p, with sel = p[15:0] % 5:
    - sel 0: pin_oe=0.
    - sel 1: pin_oe=1, pin_val=0.
    - sel 2: pin_oe=1, pin_val=1.
    - sel 3-4: stim ^= 1 << (p[31:16] % STIM_W).
  - Exactly one stimulus change per vector.
- SETTLE: wait SETTLE cycles, with stim held.
- COMPARE (1 cycle):
  - d = (gold_resp ^ gate_resp) & mask.
  - If d != 0: err_count increments, saturating at 2^ERR_W-1.
  - vec_idx increments.
  - If vec_idx == NUM_VECTORS-1, go to DONE; else go to APPLY.
- NUM_VECTORS=0: the run goes WARMZ -> DONE, with pass=1.
- DONE: busy=0, done=1, pass=(err_count==0); stim and pin_oe hold their last values.
- Reset mid-run: immediate return to IDLE; no partial results retained.
- Latency: start to done = 1 + 3*WARMUP + NUM_VECTORS*(SETTLE+2) cycles.

Optional Feature:
- FIRST_ERR_CAPTURE_EN
- Defined:
  - On the first COMPARE with d != 0 in a run, first_err_idx <= vec_idx and first_err_diff <= d.
  - Both are frozen for the rest of the run.
- Undefined:
  - No capture registers; first_err_idx is tied to all-ones and first_err_diff to 0.
  - err_count and pass behave identically.

Decomposition:
- Shared package pio_chk_pkg:
  - FSM state enum.
  - xorshift64 step function.
  - Default SEED constant.
  - Pin-mode select encodings (0 = Z, 1 = drive 0, 2 = drive 1).
- One sub-module, xorshift64_prng, with ports clk, resetn, reseed, step, state[63:0].
- The remainder (FSM, counters, compare) stays in pio_lockstep_checker.

Test Plan:
- Equal responses: gate_resp tied to gold_resp, NUM_VECTORS=16, mask=4'hF, pulse start.
  - Expect done=1, pass=1, err_count=0.
  - Expect done to rise exactly 1+15+16*3 = 64 cycles after start (WARMUP=5, SETTLE=1).
- Stuck bit: gate_resp = gold_resp ^ 4'b0001, NUM_VECTORS=16.
  - mask=4'hF: err_count=16, pass=0, first_err_idx=0, first_err_diff=4'b0001.
  - mask=4'hE: pass=1.
- Saturation: ERR_W=4, NUM_VECTORS=20, response always mismatched -> err_count=15, pass=0.
- Determinism: two back-to-back runs produce identical cycle-by-cycle stim/pin_oe/pin_val traces; start pulsed while busy has no effect.
- Reset and empty run:
  - Assert resetn=0 mid-RUN: all outputs return to 0 asynchronously.
  - A following start runs a full, correct sequence.
  - NUM_VECTORS=0 gives done=1, pass=1 right after WARMZ.
